// File: rtl/lif_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lif_tdm_scheduler
// Description : Time-division scheduler that shares one LIF neuron datapath
//               among N_NEURONS virtual neurons. It holds the membrane state
//               array, walks every neuron through the datapath once per time
//               step (FETCH -> ISSUE -> WAIT -> WB), writes back the updated
//               states and emits an indexed spike event stream.
// Ports       : clk_in, reset_n (async, active-low)
//               start_i / clr_i / vrst_i      - step control, bulk state load
//               busy_o / done_o               - step status
//               syn_addr_o / syn_i            - synaptic input fetch
//               lif_req_o / lif_state_o / lif_syn_o  - datapath operands
//               lif_state_i / lif_spike_i     - datapath result
//               spike_valid_o / spike_idx_o   - spike event stream
//               rd_idx_i / rd_data_o          - host state readback
// Options     : LIF_TDM_REFRAC_EN - per-neuron refractory counters
// Revision    : 1.0 - initial release
// ============================================================================
module lif_tdm_scheduler #(
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int DW         = 14,
    parameter int LIF_LAT    = 1,
    parameter int REFRAC_CYC = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             clr_i,
    input  logic [DW-1:0]    vrst_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] syn_addr_o,
    input  logic [DW-1:0]    syn_i,
    output logic             lif_req_o,
    output logic [DW-1:0]    lif_state_o,
    output logic [DW-1:0]    lif_syn_o,
    input  logic [DW-1:0]    lif_state_i,
    input  logic             lif_spike_i,
    output logic             spike_valid_o,
    output logic [IDX_W-1:0] spike_idx_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [DW-1:0]    rd_data_o
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_NEURONS - 1);
    // WAIT lasts LIF_LAT-1 cycles; the counter is loaded with LIF_LAT-2.
    localparam int c_WAIT_W = (LIF_LAT > 2) ? $clog2(LIF_LAT - 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [DW-1:0]       r_syn_hold;
    logic [DW-1:0]       r_mem [N_NEURONS];

    logic [DW-1:0]       w_syn_eff;
    logic [DW-1:0]       w_wb_state;
    logic                w_wb_spike;

`ifdef LIF_TDM_REFRAC_EN
    localparam int c_RC_W = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;

    logic [c_RC_W-1:0] r_refrac [N_NEURONS];
    logic              w_refrac_act;

    // The counter only changes in WB, so it is stable for the whole service
    // of the current neuron and can gate both ISSUE and WB.
    assign w_refrac_act = (r_refrac[r_idx] != '0);

    always_comb begin
        w_syn_eff  = w_refrac_act ? '0 : syn_i;
        w_wb_state = w_refrac_act ? vrst_i : lif_state_i;
        w_wb_spike = ~w_refrac_act & lif_spike_i;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_refrac[i] <= '0;
            end
        end else if (r_state == S_WB) begin
            if (w_refrac_act) begin
                r_refrac[r_idx] <= r_refrac[r_idx] - 1'b1;
            end else if (lif_spike_i) begin
                r_refrac[r_idx] <= c_RC_W'(REFRAC_CYC);
            end
        end
    end
`else
    always_comb begin
        w_syn_eff  = syn_i;
        w_wb_state = lif_state_i;
        w_wb_spike = lif_spike_i;
    end
`endif

    // syn_i only becomes valid during ISSUE, so the operand is passed through
    // in that cycle and held from the capture register until WB.
    assign lif_syn_o = (r_state == S_ISSUE) ? w_syn_eff : r_syn_hold;

    assign rd_data_o = (rd_idx_i <= c_LAST_IDX) ? r_mem[rd_idx_i] : '0;

    // Membrane state array: bulk load in IDLE, single write-back in WB.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && clr_i && !start_i) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_mem[i] <= vrst_i;
            end
        end else if (r_state == S_WB) begin
            r_mem[r_idx] <= w_wb_state;
        end
    end

    // Sequencer with registered outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_wait_cnt    <= '0;
            r_syn_hold    <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            syn_addr_o    <= '0;
            lif_req_o     <= 1'b0;
            lif_state_o   <= '0;
            spike_valid_o <= 1'b0;
            spike_idx_o   <= '0;
        end else begin
            lif_req_o     <= 1'b0;
            spike_valid_o <= 1'b0;
            done_o        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx      <= '0;
                        syn_addr_o <= '0;
                        busy_o     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    lif_req_o   <= 1'b1;
                    lif_state_o <= r_mem[r_idx];
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_syn_hold <= w_syn_eff;
                    if (LIF_LAT <= 1) begin
                        r_state <= S_WB;
                    end else begin
                        r_wait_cnt <= c_WAIT_W'(LIF_LAT - 2);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_WB;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_WB: begin
                    if (w_wb_spike) begin
                        spike_valid_o <= 1'b1;
                        spike_idx_o   <= r_idx;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                        syn_addr_o <= r_idx + 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
Time-division multiplexer that shares one LIF neuron datapath (DS_LIF-style: state in, synaptic input in, updated state and spike out) among N_NEURONS virtual neurons. Holds the per-neuron membrane state array, sequences each neuron through the datapath once per time step on a start pulse, and writes back updated states. Emits an indexed spike event stream. Sits between the synapse/input memory and the single shared LIF datapath.

Parameters:
N_NEURONS, 16, number of virtual neurons (2..256)
IDX_W, 4, neuron index width, clog2(N_NEURONS)
DW, 14, membrane state / synaptic input width
LIF_LAT, 1, datapath latency in cycles from request to result (>=1)
REFRAC_CYC, 3, refractory time steps after a spike (used only with LIF_TDM_REFRAC_EN)

Ports:
clk_in  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start_i  in  1  single-cycle pulse: begin one time step
clr_i  in  1  load Vrst into all states (honoured only in IDLE)
vrst_i  in  DW  reset potential
busy_o  out  1  high from start acceptance until done
done_o  out  1  one-cycle pulse at end of time step
syn_addr_o  out  IDX_W  neuron index for synaptic input fetch
syn_i  in  DW  synaptic input for syn_addr_o, valid the cycle after FETCH
lif_req_o  out  1  one-cycle pulse: datapath operands valid
lif_state_o  out  DW  current state of neuron under service
lif_syn_o  out  DW  synaptic input of neuron under service
lif_state_i  in  DW  updated state from datapath
lif_spike_i  in  1  spike flag from datapath
spike_valid_o  out  1  one-cycle spike event
spike_idx_o  out  IDX_W  index of spiking neuron
rd_idx_i  in  IDX_W  host readback index
rd_data_o  out  DW  state[rd_idx_i], combinational

Behaviour:
- Reset: state array all 0, FSM IDLE, idx 0; busy_o, done_o, lif_req_o, spike_valid_o = 0; syn_addr_o, lif_state_o, lif_syn_o, spike_idx_o = 0.
- FSM: IDLE -> FETCH -> ISSUE -> WAIT (LIF_LAT-1 cycles; skipped when LIF_LAT=1) -> WB -> FETCH (next idx) or DONE -> IDLE.
- IDLE: start_i=1 -> idx=0, busy_o=1, FETCH. clr_i=1 (no start) -> all states = vrst_i next cycle. start_i and clr_i together: start wins, clr ignored.
- FETCH: syn_addr_o=idx for one cycle.
- ISSUE: lif_req_o=1, lif_state_o=state[idx], lif_syn_o=syn_i sampled this cycle; operands held until WB.
- WB (LIF_LAT cycles after ISSUE): state[idx] <= lif_state_i; lif_spike_i=1 -> spike_valid_o=1, spike_idx_o=idx next cycle. idx==N_NEURONS-1 -> DONE, else idx+1, FETCH.
- DONE: done_o=1 for one cycle, busy_o=0, -> IDLE.
- Per neuron LIF_LAT+2 cycles; done_o asserted N_NEURONS*(LIF_LAT+2)+1 cycles after the edge sampling start_i.
- start_i/clr_i while busy: ignored, no queuing.
- Neurons serviced strictly in ascending index; no wrap within a step.
- Reset mid-step: immediate return to reset values; partial step discarded.
- rd_idx_i >= N_NEURONS: rd_data_o = 0.

Optional Feature:
LIF_TDM_REFRAC_EN: per-neuron refractory counter (clog2(REFRAC_CYC+1) bits, reset 0). In WB, a spike loads counter=REFRAC_CYC. At ISSUE, counter!=0 -> lif_req_o still pulses but lif_syn_o forced 0; at WB state forced to vrst_i, lif_spike_i ignored, counter decrements. Without macro: no counters, every neuron integrates every step.

Test Plan:
- Reset then start, LIF_LAT=1, N=16 -> syn_addr_o 0..15 in order, 16 lif_req_o pulses, done_o 49 cycles after start, busy_o low after.
- Datapath model returns state+syn, syn_i=100 all -> after 3 steps rd_data_o=300 for every index.
- Model spikes at neuron 5 only -> exactly one spike_valid_o with spike_idx_o=5 per step.
- start_i pulsed mid-step and clr_i mid-step -> no effect; step finishes on schedule, states unchanged by clr.
- reset_n asserted at neuron 7 of step -> all outputs 0, states 0; next start runs full 16-neuron step.
- LIF_TDM_REFRAC_EN, REFRAC_CYC=3: neuron 2 spikes step 1 -> steps 2-4 lif_syn_o=0, state=vrst_i, no spike; integrates again at step 5.
